// File: rtl/div_unit_pkg.sv
// div_defs: encodings shared by the divider and by the EX stage and stall
// controller that drive it.
//   div_state_e      : divider FSM states
//   DivResult*       : levels of ready_o
//   DivStart/DivStop : levels of start_i
//   ZeroWord/DoubleZero : 32-bit and 64-bit zero constants used by the HI/LO path
package div_defs;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [63:0] DoubleZero = 64'h0;

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   signed_div_i   : 1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i      : dividend, opdata2_i : divisor
//   start_i        : request, held high until ready_o is seen
//   annul_i        : cancel a pending or running division
//   result_o       : {remainder, quotient} (upper half to HI, lower to LO)
//   ready_o        : result_o valid
//
// Handshake: the requester raises start_i and holds it together with the
// operands' first value; the divider captures the operands on the edge that
// leaves DIV_FREE and ignores them afterwards. ready_o is held with result_o
// until start_i is seen low, after which both return to 0 on the next edge.
// A new division needs at least one cycle of start_i low in between.
module div_unit
  import div_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  div_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [2*DATA_W:0]       work;
  logic [DATA_W-1:0]       divisor_q;
  logic                    neg_q;
  logic                    neg_r;

  logic [DATA_W-1:0]       mag1;
  logic [DATA_W-1:0]       mag2;
  logic [DATA_W:0]         diff;
  logic [DATA_W-1:0]       fin_q;
  logic [DATA_W-1:0]       fin_r;

  always_comb begin
    mag1 = opdata1_i;
    mag2 = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) mag1 = -opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1]) mag2 = -opdata2_i;

    // Trial subtraction one bit wider than the operands; the top bit is the
    // borrow that tells whether the partial remainder was smaller.
    diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

    // After the last iteration the quotient sits in the low word and the
    // remainder one position above the high word (the final shift left it there).
    fin_q = work[DATA_W-1:0];
    fin_r = work[2*DATA_W:DATA_W+1];
    if (neg_q) fin_q = -work[DATA_W-1:0];
    if (neg_r) fin_r = -work[2*DATA_W:DATA_W+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      work      <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            neg_q     <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r     <= signed_div_i & opdata1_i[DATA_W-1];
            divisor_q <= mag2;
            cnt       <= '0;
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              // Dividend goes in one bit up so the first compare already sees
              // its MSB in the high word.
              work  <= {{DATA_W{1'b0}}, mag1, 1'b0};
              state <= DIV_ON;
            end
          end
        end

        DIV_BY_ZERO: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            work  <= '0;
          end else if (cnt != CNT_W'(DATA_W)) begin
            if (diff[DATA_W]) begin
              work <= {work[2*DATA_W-1:0], 1'b0};
            end else begin
              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {fin_r, fin_q};
            ready_o  <= DivResultReady;
            state    <= DIV_END;
          end
        end

        DIV_END: begin
          if (start_i == DivStop) begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int total = 0;
  int bad   = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain arithmetic: truncating division, remainder takes the dividend's sign,
  // 64-bit intermediates so MIN/-1 simply wraps. Divide-by-zero gives 0/0.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] b);
    return (b == 32'd0) ? 2 : 34;
  endfunction

  // ---------------- driver tasks ----------------
  // Raise start with the operands and count rising edges until ready is seen.
  // lat=100 means the bound expired. With scramble set, the operand inputs are
  // overwritten with noise after the capture edge.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [63:0] res, output int lat);
    @(negedge clk);
    signed_div = sgn;
    op1 = a;
    op2 = b;
    start = 1'b1;
    lat = 0;
    res = '0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (ready) break;
      if (scramble) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = $urandom_range(0, 1);
      end
    end
    if (!ready) lat = 100;
    res = result;
  endtask

  // Drop start; report outputs one edge later.
  task automatic end_div(output logic [63:0] res, output logic rdy);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    res = result;
    rdy = ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (result !== 64'd0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: result=%h ready=%b want 0/0", result, ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] want, input bit scramble);
    logic [63:0] res, res2;
    logic        rdy;
    int          lat;
    run_div(sgn, a, b, scramble, res, lat);
    total++;
    if (lat !== model_lat(b)) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, model_lat(b));
    end
    total++;
    if (res !== want) begin
      bad++;
      $display("FAIL %s_result: got %h want %h", name, res, want);
    end
    end_div(res2, rdy);
    total++;
    if (rdy !== 1'b0 || res2 !== 64'd0) begin
      bad++;
      $display("FAIL %s_release: result=%h ready=%b want 0/0", name, res2, rdy);
    end
  endtask

  task automatic test_directed();
    check_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    check_div("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    check_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
    check_div("sdiv_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
    check_div("div_zero", 1'b1, 32'd1234, 32'd0, 64'd0, 1'b0);
  endtask

  // Result and ready hold while start stays high; annul in DIV_END is ignored.
  task automatic test_hold_end();
    logic [63:0] res, res2;
    logic        rdy;
    int          lat;
    run_div(1'b0, 32'd1000, 32'd3, 1'b0, res, lat);
    @(negedge clk);
    annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || result !== model(1'b0, 32'd1000, 32'd3)) begin
      bad++;
      $display("FAIL hold_end: result=%h ready=%b want %h/1", result, ready, model(1'b0, 32'd1000, 32'd3));
    end
    @(negedge clk);
    annul = 1'b0;
    end_div(res2, rdy);
    total++;
    if (rdy !== 1'b0) begin
      bad++;
      $display("FAIL hold_end_release: ready=%b want 0", rdy);
    end
  endtask

  task automatic test_annul();
    bit seen;
    // annul on the 10th DIV_ON edge
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd5000; op2 = 32'd9; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL annul_on: ready asserted after annul, want never");
    end
    // annul together with start in DIV_FREE: nothing starts
    @(negedge clk);
    op1 = 32'd77; op2 = 32'd0; start = 1'b1; annul = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL annul_free: ready asserted with annul+start, want never");
    end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat;
    // mid DIV_ON, between edges
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd999; op2 = 32'd4; start = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (result !== 64'd0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL async_rst_on: result=%h ready=%b want 0/0", result, ready);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    // in DIV_END, where result is nonzero
    run_div(1'b0, 32'd999, 32'd4, 1'b0, res, lat);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (result !== 64'd0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL async_rst_end: result=%h ready=%b want 0/0", result, ready);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    check_div("after_rst", 1'b1, 32'hFFFFFC19, 32'd10, model(1'b1, 32'hFFFFFC19, 32'd10), 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit          sgn;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 15);
        1: b = 32'hFFFFFFFF - $urandom_range(0, 15);
        2: b = (i % 6 == 0) ? 32'd0 : $urandom;
        default: b = $urandom;
      endcase
      sgn = $urandom_range(0, 1);
      check_div($sformatf("rand%0d", i), sgn, a, b, model(sgn, a, b), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_end();
    test_annul();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
